// File: rtl/tt_check_pkg.sv
// Shared state type, sizing constants and coverage helper for the truth-table checker.
package tt_check_pkg;

    localparam int N_IN_DEFAULT = 4;
    localparam int NVEC         = 2**N_IN_DEFAULT;
    localparam int MAX_N_IN     = 8;
    localparam int MAX_VEC      = 2**MAX_N_IN;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Bitmaps are zero-padded to MAX_VEC so one helper serves every N_IN up to MAX_N_IN.
    function automatic logic all_covered(input logic [MAX_VEC-1:0] bitmap,
                                         input int unsigned         nvec);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_VEC; i++) begin
            if ((i < nvec) && !bitmap[i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/tt_response_store.sv
// Captured/covered bitmaps with a per-index write that classifies each sample
// as a first hit or a repeat that disagrees with the stored value.
module tt_response_store
    import tt_check_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 wr_en_i,
    input  logic [N_IN-1:0]      wr_idx_i,
    input  logic                 wr_f_i,
    output logic [2**N_IN-1:0]   captured_o,
    output logic [2**N_IN-1:0]   covered_o,
    output logic [2**N_IN-1:0]   covered_nxt_o,
    output logic                 first_hit_o,
    output logic                 repeat_conflict_o
);

    localparam int NV = 2**N_IN;

    logic [NV-1:0] captured_q, captured_d;
    logic [NV-1:0] covered_q,  covered_d;

    // Only the first sample of a vector is stored; later ones are just compared.
    always_comb begin
        captured_d        = captured_q;
        covered_d         = covered_q;
        first_hit_o       = 1'b0;
        repeat_conflict_o = 1'b0;
        if (clear_i) begin
            captured_d = '0;
            covered_d  = '0;
        end else if (wr_en_i) begin
            if (!covered_q[wr_idx_i]) begin
                first_hit_o          = 1'b1;
                captured_d[wr_idx_i] = wr_f_i;
                covered_d[wr_idx_i]  = 1'b1;
            end else if (captured_q[wr_idx_i] != wr_f_i) begin
                repeat_conflict_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured_q <= '0;
            covered_q  <= '0;
        end else begin
            captured_q <= captured_d;
            covered_q  <= covered_d;
        end
    end

    assign captured_o    = captured_q;
    assign covered_o     = covered_q;
    assign covered_nxt_o = covered_d;

endmodule

// File: rtl/truth_table_checker.sv
// Rebuilds a combinational DUT's truth table from (vector, f) samples, compares it
// against EXP_TABLE and reports pass/fail once every input vector has been seen.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                 N_IN      = N_IN_DEFAULT,
    parameter logic [2**N_IN-1:0] EXP_TABLE = 16'hF0E8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 in_f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [2**N_IN-1:0]   covered,
    output logic [N_IN:0]        mismatch_cnt,
    output logic                 err_seen,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 conflict
);

    localparam int NV = 2**N_IN;

    state_e          state_q, state_d;
    logic [N_IN:0]   mismatchCnt_q, mismatchCnt_d;
    logic            errSeen_q, errSeen_d;
    logic [N_IN-1:0] firstErr_q, firstErr_d;
    logic            conflict_q, conflict_d;

    logic            sampleEn;
    logic            firstHit;
    logic            repeatConflict;
    logic            isMismatch;
    logic [NV-1:0]   coveredNext;

    // start has priority: a sample arriving on the same edge is dropped.
    assign sampleEn   = (state_q == COLLECT) && in_valid && !start;
    assign isMismatch = firstHit && (in_f != EXP_TABLE[in_vec]);

    tt_response_store #(
        .N_IN (N_IN)
    ) u_store (
        .clk               (clk),
        .rst_n             (rst_n),
        .clear_i           (start),
        .wr_en_i           (sampleEn),
        .wr_idx_i          (in_vec),
        .wr_f_i            (in_f),
        .captured_o        (captured),
        .covered_o         (covered),
        .covered_nxt_o     (coveredNext),
        .first_hit_o       (firstHit),
        .repeat_conflict_o (repeatConflict)
    );

    // Looking at next-cycle coverage lets the completing edge also enter DONE.
    always_comb begin
        state_d       = state_q;
        mismatchCnt_d = mismatchCnt_q;
        errSeen_d     = errSeen_q;
        firstErr_d    = firstErr_q;
        conflict_d    = conflict_q;
        if (start) begin
            state_d       = COLLECT;
            mismatchCnt_d = '0;
            errSeen_d     = 1'b0;
            firstErr_d    = '0;
            conflict_d    = 1'b0;
        end else if (state_q == COLLECT) begin
            if (isMismatch) begin
                mismatchCnt_d = mismatchCnt_q + 1'b1;
                if (!errSeen_q) begin
                    errSeen_d  = 1'b1;
                    firstErr_d = in_vec;
                end
            end
            if (repeatConflict) begin
                conflict_d = 1'b1;
            end
            if (firstHit && all_covered(MAX_VEC'(coveredNext), NV)) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mismatchCnt_q <= '0;
            errSeen_q     <= 1'b0;
            firstErr_q    <= '0;
            conflict_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mismatchCnt_q <= mismatchCnt_d;
            errSeen_q     <= errSeen_d;
            firstErr_q    <= firstErr_d;
            conflict_q    <= conflict_d;
        end
    end

    assign busy          = (state_q == COLLECT);
    assign done          = (state_q == DONE);
    assign pass          = done && (mismatchCnt_q == '0) && !conflict_q;
    assign mismatch_cnt  = mismatchCnt_q;
    assign err_seen      = errSeen_q;
    assign first_err_idx = firstErr_q;
    assign conflict      = conflict_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomised and directed bench for truth_table_checker against a table-level reference model.
module tb_truth_table_checker;

    localparam logic [15:0] EXP = 16'hF0E8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_vec;
    logic        in_f;
    logic        busy, done, pass, err_seen, conflict;
    logic [15:0] captured, covered;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_err_idx;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] cap;
        logic [15:0] cov;
        logic [4:0]  mis;
        logic        err;
        logic [3:0]  fidx;
        logic        conf;
    } snap_t;

    // Reference model: phase 0 = idle, 1 = collecting, 2 = finished.
    int mPhase;
    bit mCap [16];
    bit mCov [16];
    int mMis;
    bit mErr;
    int mFirst;
    bit mConf;

    truth_table_checker #(
        .N_IN      (4),
        .EXP_TABLE (EXP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_vec        (in_vec),
        .in_f          (in_f),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .captured      (captured),
        .covered       (covered),
        .mismatch_cnt  (mismatch_cnt),
        .err_seen      (err_seen),
        .first_err_idx (first_err_idx),
        .conflict      (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t dutSnap();
        snap_t s;
        s.busy = busy; s.done = done; s.pass = pass;
        s.cap = captured; s.cov = covered; s.mis = mismatch_cnt;
        s.err = err_seen; s.fidx = first_err_idx; s.conf = conflict;
        return s;
    endfunction

    function void modelClear();
        for (int i = 0; i < 16; i++) begin
            mCap[i] = 1'b0;
            mCov[i] = 1'b0;
        end
        mMis = 0; mErr = 1'b0; mFirst = 0; mConf = 1'b0;
    endfunction

    function void modelStep(bit st, bit v, int vec, bit f);
        int n;
        if (st) begin
            modelClear();
            mPhase = 1;
        end else if (mPhase == 1 && v) begin
            if (!mCov[vec]) begin
                mCov[vec] = 1'b1;
                mCap[vec] = f;
                if (f != EXP[vec]) begin
                    mMis++;
                    if (!mErr) begin
                        mErr = 1'b1;
                        mFirst = vec;
                    end
                end
                n = 0;
                for (int i = 0; i < 16; i++) n += mCov[i] ? 1 : 0;
                if (n == 16) mPhase = 2;
            end else if (mCap[vec] != f) begin
                mConf = 1'b1;
            end
        end
    endfunction

    function automatic snap_t modelSnap();
        snap_t s;
        s.busy = (mPhase == 1);
        s.done = (mPhase == 2);
        s.pass = (mPhase == 2) && (mMis == 0) && !mConf;
        for (int i = 0; i < 16; i++) begin
            s.cap[i] = mCap[i];
            s.cov[i] = mCov[i];
        end
        s.mis = 5'(mMis);
        s.err = mErr;
        s.fidx = 4'(mFirst);
        s.conf = mConf;
        return s;
    endfunction

    task automatic step(input bit st, input bit v, input int vec, input bit f);
        start = st; in_valid = v; in_vec = vec[3:0]; in_f = f;
        @(posedge clk);
        modelStep(st, v, vec, f);
        #1;
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = '0; in_f = 1'b0;
        mPhase = 0; modelClear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dutSnap() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", dutSnap());
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 5, 1);
        checks++;
        if (covered !== 16'h0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_valid: covered=%h busy=%b want 0000/0", covered, busy);
        end
    endtask

    task automatic test_ascending();
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, i, EXP[i]);
            if (i == 14) begin
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL asc_early_done: got %b want 0", done);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || captured !== 16'hF0E8 ||
            covered !== 16'hFFFF || mismatch_cnt !== 5'd0) begin
            failures++;
            $display("FAIL asc_result: done=%b pass=%b cap=%h cov=%h mis=%0d want 1 1 f0e8 ffff 0",
                     done, pass, captured, covered, mismatch_cnt);
        end
        step(0, 1, 3, 0);
        checks++;
        if (dutSnap() !== modelSnap() || conflict !== 1'b0) begin
            failures++;
            $display("FAIL done_ignores_valid: got %h want %h", dutSnap(), modelSnap());
        end
    endtask

    task automatic test_stuck_zero();
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, i, 0);
        checks++;
        if (mismatch_cnt !== 5'd8 || err_seen !== 1'b1 || first_err_idx !== 4'd3 ||
            pass !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL stuck0: mis=%0d err=%b fidx=%0d pass=%b done=%b want 8 1 3 0 1",
                     mismatch_cnt, err_seen, first_err_idx, pass, done);
        end
    endtask

    task automatic test_repeat();
        step(1, 0, 0, 0);
        step(0, 1, 5, 1);
        step(0, 1, 5, 0);
        checks++;
        if (conflict !== 1'b1 || captured[5] !== 1'b1 || covered !== 16'h0020) begin
            failures++;
            $display("FAIL repeat_conflict: conf=%b cap=%h cov=%h want 1 0020 0020",
                     conflict, captured, covered);
        end
        for (int i = 0; i < 16; i++) if (i != 5) step(0, 1, i, EXP[i]);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || mismatch_cnt !== 5'd0 || captured[5] !== 1'b1) begin
            failures++;
            $display("FAIL repeat_final: done=%b pass=%b mis=%0d cap5=%b want 1 0 0 1",
                     done, pass, mismatch_cnt, captured[5]);
        end
    endtask

    task automatic test_descending_gaps();
        bit bad;
        bad = 1'b0;
        step(1, 0, 0, 0);
        for (int i = 15; i >= 0; i--) begin
            step(0, 1, i, EXP[i]);
            if (i > 0) begin
                if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
                step(0, 0, 0, 0);
                step(0, 0, 0, 0);
                if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
            end
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL desc_busy: busy/done left collection early, got bad=1 want 0");
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL desc_final: done=%b pass=%b busy=%b want 1 1 0", done, pass, busy);
        end
    endtask

    task automatic test_start_interaction();
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, i, ~EXP[i]);
        checks++;
        if (dutSnap() !== modelSnap()) begin
            failures++;
            $display("FAIL pre_restart: got %h want %h", dutSnap(), modelSnap());
        end
        step(1, 0, 0, 0);
        checks++;
        if (covered !== 16'h0000 || mismatch_cnt !== 5'd0 || err_seen !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear: cov=%h mis=%0d err=%b busy=%b want 0000 0 0 1",
                     covered, mismatch_cnt, err_seen, busy);
        end
        step(0, 1, 2, 1);
        step(1, 1, 3, 0);
        checks++;
        if (covered !== 16'h0000 || mismatch_cnt !== 5'd0) begin
            failures++;
            $display("FAIL start_drops_sample: cov=%h mis=%0d want 0000 0", covered, mismatch_cnt);
        end
        step(0, 1, 3, EXP[3]);
        checks++;
        if (covered !== 16'h0008 || captured !== 16'h0008) begin
            failures++;
            $display("FAIL after_drop: cov=%h cap=%h want 0008 0008", covered, captured);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, i, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        mPhase = 0; modelClear();
        checks++;
        if (dutSnap() !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h want 0", dutSnap());
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        checks++;
        if (dutSnap() !== modelSnap()) begin
            failures++;
            $display("FAIL post_reset_idle: got %h want %h", dutSnap(), modelSnap());
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int round = 0; round < 4; round++) begin
            step(1, 0, 0, 0);
            for (int cyc = 0; cyc < 400 && mPhase == 1; cyc++) begin
                int v;
                bit valid, st, f;
                v     = int'($urandom_range(0, 15));
                valid = ($urandom_range(0, 2) != 0);
                st    = ($urandom_range(0, 79) == 0);
                f     = EXP[v] ^ ($urandom_range(0, 9) == 0);
                step(st, valid, v, f);
                checks++;
                if (dutSnap() !== modelSnap()) begin
                    failures++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL random_r%0d_c%0d: got %h want %h", round, cyc, dutSnap(), modelSnap());
                end
            end
            checks++;
            if (mPhase != 2 || done !== 1'b1) begin
                failures++;
                $display("FAIL random_complete_r%0d: done=%b model_phase=%0d want 1 2", round, done, mPhase);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_stuck_zero();
        test_repeat();
        test_descending_gaps();
        test_start_interaction();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
